// File: rtl/crop_pkg.sv
// Shared types for the crop filter: FSM states and the pixel type.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package crop_pkg;

   localparam int PIX_W = 8;

   typedef logic [PIX_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_SOF,
      ST_CAPTURE,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/crop_buffer.sv
// Simple dual-port pixel RAM holding one cropped window.
// Latency: read data appears one cycle after i_rd_en; writes land at the clock edge.
// Backpressure: none; o_rd_data holds its value while i_rd_en is low.
module crop_buffer #(
   parameter int DEPTH = 100,
   parameter int AW    = 7
) (
   input  logic          i_clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [7:0]    i_wr_data,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_addr,
   output logic [7:0]    o_rd_data
);
   import crop_pkg::*;

   pixel_t r_mem [DEPTH];
   pixel_t r_rd_data;

   assign o_rd_data = r_rd_data;

   // Write port plus registered read port; no reset, contents are don't-care.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

endmodule

// File: rtl/crop_filter.sv
// Captures one raw frame, keeps the crop window in a buffer, then streams it out with its max.
// Latency: ap_done one cycle after the last raw pixel; first output two cycles into DRAIN.
// Backpressure: s_axis_tready only in WAIT_SOF/CAPTURE; m_axis holds data while !m_axis_tready.
module crop_filter #(
   parameter int IN_ROWS    = 16,
   parameter int IN_COLS    = 16,
   parameter int OUT_ROWS   = 10,
   parameter int OUT_COLS   = 10,
   parameter int ROW_OFFSET = 0,
   parameter int COL_OFFSET = 0
) (
   input  logic       clk,
   input  logic       srst,
   input  logic       ap_start,
   output logic       ap_idle,
   output logic       ap_ready,
   output logic       ap_done,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tuser,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic [7:0] m_axis_tdata,
   output logic [7:0] max_value
);
   import crop_pkg::*;

   localparam int DEPTH = OUT_ROWS * OUT_COLS;
   localparam int RW    = $clog2(IN_ROWS) + 1;
   localparam int CW    = $clog2(IN_COLS) + 1;
   localparam int AW    = $clog2(DEPTH) + 1;
   localparam int BAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [RW-1:0] ROW_LO   = RW'(ROW_OFFSET);
   localparam logic [RW-1:0] ROW_HI   = RW'(ROW_OFFSET + OUT_ROWS);
   localparam logic [CW-1:0] COL_LO   = CW'(COL_OFFSET);
   localparam logic [CW-1:0] COL_HI   = CW'(COL_OFFSET + OUT_COLS);
   localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);
   localparam logic [AW-1:0] A_LAST   = AW'(DEPTH - 1);
   localparam logic [AW-1:0] A_DEPTH  = AW'(DEPTH);

   state_t        r_state, w_next;
   logic [RW-1:0] r_row, w_row;
   logic [CW-1:0] r_col, w_col;
   logic [AW-1:0] r_waddr, w_waddr;
   pixel_t        r_max_run, r_max_out, w_max_base, w_max_new;
   logic          r_done;
   logic          w_start, w_acc, w_proc, w_inwin, w_last;

   logic [AW-1:0] r_raddr, r_ocnt;
   logic          r_rd_vld, r_tvalid;
   pixel_t        r_tdata, w_rd_data;
   logic          w_ren, w_ld, w_hs;

   assign ap_idle       = (r_state == ST_IDLE);
   assign ap_ready      = (r_state == ST_IDLE);
   assign ap_done       = r_done;
   assign s_axis_tready = (r_state == ST_WAIT_SOF) || (r_state == ST_CAPTURE);
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tdata  = r_tdata;
   assign max_value     = r_max_out;

   // A SOF beat always counts as pixel (0,0) with a fresh window and max.
   assign w_start    = ap_start && (r_state == ST_IDLE);
   assign w_acc      = s_axis_tvalid && s_axis_tready;
   assign w_proc     = w_acc && (s_axis_tuser || (r_state == ST_CAPTURE));
   assign w_row      = s_axis_tuser ? '0 : r_row;
   assign w_col      = s_axis_tuser ? '0 : r_col;
   assign w_waddr    = s_axis_tuser ? '0 : r_waddr;
   assign w_max_base = s_axis_tuser ? '0 : r_max_run;
   assign w_inwin    = (w_row >= ROW_LO) && (w_row < ROW_HI) &&
                       (w_col >= COL_LO) && (w_col < COL_HI);
   assign w_max_new  = (w_inwin && (s_axis_tdata > w_max_base)) ? s_axis_tdata : w_max_base;
   assign w_last     = w_proc && (w_row == ROW_LAST) && (w_col == COL_LAST);

   // Drain pipeline: RAM output stage feeds the output register; a read is
   // issued only when the RAM stage is empty or moving, so no beat is lost.
   assign w_hs  = r_tvalid && m_axis_tready;
   assign w_ld  = r_rd_vld && (!r_tvalid || m_axis_tready);
   assign w_ren = (r_state == ST_DRAIN) && (r_raddr < A_DEPTH) && (!r_rd_vld || w_ld);

   // State register.
   always_ff @(posedge clk or posedge srst) begin
      if (srst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (ap_start) w_next = ST_WAIT_SOF;
         ST_WAIT_SOF: if (w_last) w_next = ST_DRAIN; else if (w_proc) w_next = ST_CAPTURE;
         ST_CAPTURE:  if (w_last) w_next = ST_DRAIN;
         ST_DRAIN:    if (w_hs && (r_ocnt == A_LAST)) w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   // Raster position, write address and running max during capture.
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         r_row     <= '0;
         r_col     <= '0;
         r_waddr   <= '0;
         r_max_run <= '0;
         r_max_out <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_start) begin
            r_row     <= '0;
            r_col     <= '0;
            r_waddr   <= '0;
            r_max_run <= '0;
            r_max_out <= '0;
         end else if (w_proc) begin
            if (w_col == COL_LAST) begin
               r_col <= '0;
               r_row <= w_row + RW'(1);
            end else begin
               r_col <= w_col + CW'(1);
               r_row <= w_row;
            end
            r_waddr   <= w_inwin ? (w_waddr + AW'(1)) : w_waddr;
            r_max_run <= w_max_new;
            // A zero max would make the downstream divide by zero.
            if (w_last) r_max_out <= (w_max_new == '0) ? 8'd1 : w_max_new;
         end
      end
   end

   // Read address, output count and the two drain pipeline stages.
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         r_raddr  <= '0;
         r_ocnt   <= '0;
         r_rd_vld <= 1'b0;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
      end else begin
         if (w_start || w_last) begin
            r_raddr  <= '0;
            r_ocnt   <= '0;
            r_rd_vld <= 1'b0;
         end else begin
            if (w_ren) r_raddr <= r_raddr + AW'(1);
            if (w_hs)  r_ocnt  <= r_ocnt + AW'(1);
            if (w_ren)     r_rd_vld <= 1'b1;
            else if (w_ld) r_rd_vld <= 1'b0;
         end
         if (w_ld) r_tdata <= w_rd_data;
         if (w_ld)      r_tvalid <= 1'b1;
         else if (w_hs) r_tvalid <= 1'b0;
      end
   end

   crop_buffer #(
      .DEPTH (DEPTH),
      .AW    (BAW)
   ) u_buf (
      .i_clk     (clk),
      .i_wr_en   (w_proc && w_inwin),
      .i_wr_addr (w_waddr[BAW-1:0]),
      .i_wr_data (s_axis_tdata),
      .i_rd_en   (w_ren),
      .i_rd_addr (r_raddr[BAW-1:0]),
      .o_rd_data (w_rd_data)
   );

endmodule

// File: tb/tb_crop_filter.sv
// Self-checking bench for crop_filter: 8x8 frames, 4x4 window at (2,3), random stimulus.
// Latency: expected stream and max come from a frame-level model, compared on every output handshake.
// Backpressure: m_axis_tready is held high, toggled, or randomized; input beats carry random gaps.
module tb_crop_filter;

   localparam int IR = 8, IC = 8, ORW = 4, OCL = 4, RO = 2, CO = 3, NPIX = IR * IC;

   logic       clk, srst, ap_start, ap_idle, ap_ready, ap_done;
   logic       s_axis_tvalid, s_axis_tready, s_axis_tuser;
   logic [7:0] s_axis_tdata;
   logic       m_axis_tvalid, m_axis_tready;
   logic [7:0] m_axis_tdata, max_value;

   int         total = 0, bad = 0;
   int         done_cnt = 0;
   int         rdy_mode = 0;
   int         exp_max = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] pix1[NPIX];
   logic [7:0] pix2[NPIX];

   crop_filter #(
      .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(ORW), .OUT_COLS(OCL),
      .ROW_OFFSET(RO), .COL_OFFSET(CO)
   ) dut (
      .clk(clk), .srst(srst), .ap_start(ap_start),
      .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .max_value(max_value)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Downstream ready pattern.
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // Output monitor: order, content and hold-while-stalled.
   initial begin
      logic       stalled_prev;
      logic [7:0] prev_dat;
      stalled_prev = 1'b0;
      prev_dat     = '0;
      forever begin
         @(negedge clk);
         if (ap_done) done_cnt++;
         if (m_axis_tvalid) begin
            if (stalled_prev) check("hold_stable", m_axis_tdata, prev_dat);
            if (m_axis_tready) begin
               rx_q.push_back(m_axis_tdata);
               check("beat_expected", int'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) check("pixel", m_axis_tdata, exp_q.pop_front());
            end
            stalled_prev = !m_axis_tready;
            prev_dat     = m_axis_tdata;
         end else begin
            stalled_prev = 1'b0;
         end
      end
   end

   task automatic check_reset_state();
      check("rst_idle", ap_idle, 1);
      check("rst_ready", ap_ready, 1);
      check("rst_done", ap_done, 0);
      check("rst_m_tvalid", m_axis_tvalid, 0);
      check("rst_s_tready", s_axis_tready, 0);
      check("rst_max", max_value, 0);
   endtask

   task automatic push_beat(input logic [7:0] d, input logic u);
      int k;
      if ($urandom_range(0, 3) == 0) begin
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      k = 0;
      while (k < 200) begin
         @(negedge clk);
         if (s_axis_tready) break;
         k++;
      end
      check("input_accepted", int'(k < 200), 1);
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic start_frame();
      int k;
      k = 0;
      while (!ap_ready && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      ap_start = 1'b1;
      @(posedge clk);
      #1;
      ap_start = 1'b0;
      check("max_clear_on_start", max_value, 0);
   endtask

   // kind: 0 ramp (row*IC+col), 1 all zero, 2 random. restart_at>0 sends that
   // many beats of an abandoned frame before the real SOF.
   task automatic run_frame(input int kind, input int junk, input int restart_at);
      int  base, mx;
      bit  seen;
      for (int i = 0; i < NPIX; i++) begin
         pix1[i] = 8'($urandom_range(0, 255));
         case (kind)
            0:       pix2[i] = 8'(i);
            1:       pix2[i] = 8'd0;
            default: pix2[i] = 8'($urandom_range(0, 255));
         endcase
      end
      mx = 0;
      for (int r = RO; r < RO + ORW; r++)
         for (int c = CO; c < CO + OCL; c++) begin
            exp_q.push_back(pix2[r * IC + c]);
            if (int'(pix2[r * IC + c]) > mx) mx = int'(pix2[r * IC + c]);
         end
      exp_max = (mx == 0) ? 1 : mx;
      rx_q.delete();
      base = done_cnt;

      start_frame();
      for (int i = 0; i < junk; i++) push_beat(8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < restart_at; i++) push_beat(pix1[i], i == 0);
      for (int i = 0; i < NPIX; i++) begin
         push_beat(pix2[i], i == 0);
         if (i == 10) begin
            ap_start = 1'b1;
            @(posedge clk);
            #1;
            ap_start = 1'b0;
         end
      end

      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         #1;
         if (ap_done) seen = 1'b1;
      end
      check("done_seen", seen, 1);
      check("max_value", max_value, exp_max);

      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         #1;
         if (ap_idle && exp_q.size() == 0) break;
      end
      check("drain_left", exp_q.size(), 0);
      check("back_idle", ap_idle, 1);
      check("done_once", done_cnt - base, 1);
      check("max_hold", max_value, exp_max);
      exp_q.delete();
   endtask

   task automatic lit_rx(input string name, input int idx, input int val);
      if (idx < rx_q.size()) check(name, rx_q[idx], val);
      else check({name, "_len"}, rx_q.size(), idx + 1);
   endtask

   initial begin
      srst = 1'b1;
      ap_start = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata = '0;
      s_axis_tuser = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      srst = 1'b0;

      // Ramp frame: window rows 2..5, cols 3..6.
      rdy_mode = 0;
      run_frame(0, 0, 0);
      lit_rx("ramp_first", 0, 19);
      lit_rx("ramp_row1", 4, 27);
      lit_rx("ramp_last", 15, 46);
      check("ramp_max", max_value, 46);

      // Non-SOF beats before the frame are dropped.
      run_frame(0, 3, 0);
      lit_rx("junk_first", 0, 19);
      lit_rx("junk_last", 15, 46);

      // All-zero frame clamps max to one.
      run_frame(1, 0, 0);
      check("zero_max", max_value, 1);

      // Toggling downstream ready.
      rdy_mode = 1;
      run_frame(0, 0, 0);
      lit_rx("toggle_mid", 9, 36);
      rdy_mode = 0;

      // Reset mid-capture, then a clean frame.
      start_frame();
      for (int i = 0; i < 20; i++) push_beat(8'(i), i == 0);
      srst = 1'b1;
      #1;
      check_reset_state();
      repeat (2) @(posedge clk);
      #1;
      srst = 1'b0;
      run_frame(0, 0, 0);
      lit_rx("post_rst_first", 0, 19);
      lit_rx("post_rst_last", 15, 46);

      // Second SOF at pixel 30.
      run_frame(2, 0, 30);

      // Randomized frames.
      rdy_mode = 2;
      for (int n = 0; n < 6; n++)
         run_frame(2, $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 63) : 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
